stopwatch_cu: RTL
=================

Name: stopwatch_cu

Overview:
Control unit and time-base for the stopwatch. Decodes run/stop, clear and lap button levels into a STOP/RUN/CLEAR state machine, generates the 1/100 s tick, and maintains the centisecond (0-99) and second (0-59) counters. Its msec/sec outputs drive the 7-segment display controller directly. Button inputs arrive already debounced.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
TICK_HZ, 100, time-base rate in Hz; one msec count per tick

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
btn_run_stop  input  1  debounced level; a rising edge toggles run/stop
btn_clear  input  1  debounced level; a rising edge clears the counters (STOP only)
btn_lap  input  1  debounced level; a rising edge toggles lap hold
msec  output  7  displayed centiseconds, 0-99
sec  output  6  displayed seconds, 0-59
running  output  1  high while the FSM is in RUN
lap_active  output  1  high while the display is frozen on a lap value

Behaviour:
- One clock domain. Reset is synchronous and active-high. Every flop updates only on posedge clk.
- Reset values:
  - state=STOP, tick counter=0.
  - Internal msec and sec counters=0, lap capture registers=0.
  - Button delay registers=0.
  - Outputs: msec=0, sec=0, running=0, lap_active=0.
- Edge detect:
  - Each button is registered into btn_x_d; edge_x = btn_x & ~btn_x_d.
  - A level held high produces exactly one edge.
  - A button that is high when reset deasserts does not produce an edge.
- FSM states: STOP, RUN, CLEAR.
  - STOP, edge_clear=1 -> CLEAR. Clear takes priority over run_stop when both edges occur in the same cycle.
  - STOP, edge_run_stop=1 and no clear edge -> RUN.
  - RUN, edge_run_stop=1 -> STOP. edge_clear is ignored in RUN.
  - CLEAR -> STOP unconditionally after 1 cycle. All button edges are ignored in CLEAR.
- running = (state==RUN), registered with the state.
- Tick generator:
  - TICK_DIV = CLK_FREQ/TICK_HZ. Counter width is $clog2(TICK_DIV).
  - In RUN the counter increments each cycle. On reaching TICK_DIV-1 it wraps to 0 and asserts the internal tick for 1 cycle.
  - In STOP the counter holds its value, so the sub-tick phase is preserved across pause and resume.
  - In CLEAR the counter is set to 0.
- Time counters, advanced on tick only:
  - If msec<99: msec+1.
  - Else msec->0 and the seconds counter advances: sec+1 if sec<59, else sec->0.
  - Full wrap is 59.99 -> 00.00; there is no minutes field and no overflow flag.
- CLEAR state zeroes msec, sec, the tick counter and the lap capture registers, and sets lap_active=0.
- Lap:
  - In RUN, edge_lap with lap_active=0: capture the current internal msec/sec into the lap registers and set lap_active=1.
  - In RUN, edge_lap with lap_active=1: set lap_active=0.
  - If tick and capture occur in the same cycle, the captured value is the pre-increment value.
  - In STOP, edge_lap with lap_active=1 sets lap_active=0. With lap_active=0 it is ignored.
  - edge_lap in the same cycle as edge_run_stop: both are processed, and the lap rule is evaluated against the pre-transition state.
- Outputs:
  - msec/sec = lap_active ? lap registers : internal counters.
  - Combinational mux of registered values; no extra latency.
  - Internal counting continues while lap_active=1.
- Latency:
  - A button sampled high at edge n with btn_d=0 changes state, running, lap_active and the capture at edge n.
  - The first tick after entering RUN from reset or clear occurs TICK_DIV cycles after the transition.
- Reset asserted mid-operation in any state forces all reset values on the next edge, overriding any button edges.

Test Plan:
1. TICK_DIV=10 (CLK_FREQ=1000, TICK_HZ=100): reset, pulse run_stop, wait 250 cycles -> running=1, msec=25, sec=0.
2. Run until msec=99,sec=0 then one more tick -> msec=0, sec=1. Preload to sec=59,msec=99 and tick -> 0/0.
3. RUN 35 cycles (msec=3, tick phase 5), stop, idle 100 cycles, run 5 cycles -> msec=4 (phase preserved). Clear pressed during RUN -> no change.
4. STOP with msec=42: raise clear and run_stop in the same cycle -> CLEAR for 1 cycle, then STOP with msec=0, sec=0, running=0.
5. RUN at msec=17: lap -> lap_active=1, msec held at 17 for 100 cycles. Lap again -> msec shows 27 (internal value).
6. Hold btn_run_stop high for 50 cycles -> exactly one transition. Assert rst in RUN with lap_active=1 -> next edge all outputs 0.

Source files
------------

// File: rtl/stopwatch_cu.sv
// stopwatch_cu: stopwatch control FSM, 1/100 s time-base, centisecond/second counters and lap hold.
// Ports: clk, rst (sync, active-high); btn_run_stop / btn_clear / btn_lap debounced button levels;
//        msec (0-99) and sec (0-59) displayed time; running (FSM in RUN); lap_active (display frozen on lap).
module stopwatch_cu #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_run_stop,
  input  logic       btn_clear,
  input  logic       btn_lap,
  output logic [6:0] msec,
  output logic [5:0] sec,
  output logic       running,
  output logic       lap_active
);
  localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  typedef enum logic [1:0] {STOP, RUN, CLEAR} state_t;
  state_t state_q;
  logic first_q, rs_dq, clr_dq, lap_dq;
  logic [TW-1:0] tick_cnt_q;
  logic [6:0] msec_q, lap_msec_q, msec_d;
  logic [5:0] sec_q, lap_sec_q, sec_d;
  logic running_q, lap_active_q;
  logic edge_rs, edge_clr, edge_lap, tick;
  // first_q masks the first cycle after reset so a button already held high
  // while reset releases is absorbed into the delay register, not seen as an edge.
  always_comb begin
    edge_rs  = btn_run_stop & ~rs_dq & ~first_q;
    edge_clr = btn_clear & ~clr_dq & ~first_q;
    edge_lap = btn_lap & ~lap_dq & ~first_q;
    tick     = (state_q == RUN) && (tick_cnt_q == TW'(TICK_DIV - 1));
    msec_d   = tick ? ((msec_q == 7'd99) ? 7'd0 : msec_q + 7'd1) : msec_q;
    sec_d    = (tick && msec_q == 7'd99) ? ((sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1) : sec_q;
    msec       = lap_active_q ? lap_msec_q : msec_q;
    sec        = lap_active_q ? lap_sec_q : sec_q;
    running    = running_q;
    lap_active = lap_active_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= STOP;
      first_q      <= 1'b1;
      rs_dq        <= 1'b0;
      clr_dq       <= 1'b0;
      lap_dq       <= 1'b0;
      tick_cnt_q   <= '0;
      msec_q       <= '0;
      sec_q        <= '0;
      lap_msec_q   <= '0;
      lap_sec_q    <= '0;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
    end else begin
      first_q <= 1'b0;
      rs_dq   <= btn_run_stop;
      clr_dq  <= btn_clear;
      lap_dq  <= btn_lap;
      case (state_q)
        STOP: begin
          // tick counter and time counters hold, preserving sub-tick phase across pause
          if (edge_clr) begin
            state_q <= CLEAR;
          end else if (edge_rs) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
          if (edge_lap && lap_active_q) lap_active_q <= 1'b0;
        end
        RUN: begin
          tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
          msec_q     <= msec_d;
          sec_q      <= sec_d;
          if (edge_rs) begin
            state_q   <= STOP;
            running_q <= 1'b0;
          end
          // capture takes the pre-increment counter value when it coincides with a tick
          if (edge_lap) begin
            lap_active_q <= ~lap_active_q;
            if (!lap_active_q) begin
              lap_msec_q <= msec_q;
              lap_sec_q  <= sec_q;
            end
          end
        end
        default: begin
          state_q      <= STOP;
          running_q    <= 1'b0;
          tick_cnt_q   <= '0;
          msec_q       <= '0;
          sec_q        <= '0;
          lap_msec_q   <= '0;
          lap_sec_q    <= '0;
          lap_active_q <= 1'b0;
        end
      endcase
    end
  end
endmodule
